// File: rtl/tmr_tick_gen.sv
// tmr_tick_gen
// ------------
// Triple-modular-redundant tick generator. It keeps three copies of a W-bit
// prescaler and three copies of a W-bit divisor. Each cycle the copies are
// reduced to voted values (pv, dv) by a bitwise 2-of-3 majority. All
// next-state decisions use only the voted values. All three copies are then
// rewritten from the voted next value, so a single upset copy is scrubbed
// within one cycle and cannot change tick timing.
//
// With run held high, tick pulses once every dv+1 cycles. A verification-only
// injection port can XOR a mask into one prescaler copy. Any disagreement
// between the copies is flagged one cycle later on mismatch and counted in a
// saturating error counter.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   run       in   prescaler advance enable
//   load      in   latch div and restart the prescaler (overrides run)
//   div       in   W  tick period minus one, sampled only when load=1
//   inj_en    in   fault-injection strobe
//   inj_sel   in   2  prescaler copy to corrupt (3 = none)
//   inj_mask  in   W  XOR mask applied to the selected copy
//   err_clr   in   clear err_cnt (wins over a simultaneous detection)
//   tick      out  registered one-cycle tick pulse
//   mismatch  out  registered: copies disagreed on the previous cycle
//   err_cnt   out  ECNT_W saturating count of mismatch cycles

module tmr_tick_gen #(
  parameter int W       = 8,
  parameter int ECNT_W  = 4,
  parameter int DIV_RST = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load,
  input  logic [W-1:0]      div,
  input  logic              inj_en,
  input  logic [1:0]        inj_sel,
  input  logic [W-1:0]      inj_mask,
  input  logic              err_clr,
  output logic              tick,
  output logic              mismatch,
  output logic [ECNT_W-1:0] err_cnt
);

  localparam logic [W-1:0]      DIV_RST_V = W'(DIV_RST);
  localparam logic [ECNT_W-1:0] ERR_MAX   = '1;

  // Redundant state copies
  logic [W-1:0] p_cp [3];
  logic [W-1:0] d_cp [3];

  // Voted values and next-state terms
  logic [W-1:0]      pv;
  logic [W-1:0]      dv;
  logic [W-1:0]      p_nxt;
  logic [W-1:0]      d_nxt;
  logic              tick_nxt;
  logic [W-1:0]      p_wr [3];
  logic              mm_det;
  logic [ECNT_W-1:0] err_nxt;

  // Bitwise 2-of-3 majority. One bad copy is always outvoted.
  always_comb begin
    pv = (p_cp[0] & p_cp[1]) | (p_cp[0] & p_cp[2]) | (p_cp[1] & p_cp[2]);
    dv = (d_cp[0] & d_cp[1]) | (d_cp[0] & d_cp[2]) | (d_cp[1] & d_cp[2]);
  end

  // Next-state decision from voted values only: load beats run beats hold.
  // The ">=" compare is defensive. Load zeroes the prescaler, so pv cannot
  // normally exceed dv, and pv+1 therefore cannot overflow.
  always_comb begin
    p_nxt    = pv;
    d_nxt    = dv;
    tick_nxt = 1'b0;
    if (load) begin
      d_nxt = div;
      p_nxt = '0;
    end else if (run) begin
      if (pv >= dv) begin
        p_nxt    = '0;
        tick_nxt = 1'b1;
      end else begin
        p_nxt = pv + 1'b1;
      end
    end
  end

  // Every prescaler copy gets the voted next value. The copy selected by
  // the injection port gets that value XOR the mask instead.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      p_wr[i] = p_nxt;
      if (inj_en && (inj_sel == 2'(i))) begin
        p_wr[i] = p_nxt ^ inj_mask;
      end
    end
  end

  // Disagreement detection this cycle. err_nxt feeds the counter on the
  // same edge that registers mismatch.
  always_comb begin
    mm_det = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((p_cp[i] != pv) || (d_cp[i] != dv)) begin
        mm_det = 1'b1;
      end
    end
    err_nxt = err_cnt;
    if (err_clr) begin
      err_nxt = '0;
    end else if (mm_det && (err_cnt != ERR_MAX)) begin
      err_nxt = err_cnt + 1'b1;
    end
  end

  // State register. Reset overrides load, run, injection and err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        p_cp[i] <= '0;
        d_cp[i] <= DIV_RST_V;
      end
      tick     <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        p_cp[i] <= p_wr[i];
        d_cp[i] <= d_nxt;
      end
      tick     <= tick_nxt;
      mismatch <= mm_det;
      err_cnt  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tmr_tick_gen.sv
// tb_tmr_tick_gen
// ---------------
// Scoreboard bench for tmr_tick_gen. The driver applies one input vector
// per cycle on the falling edge. It advances a behavioural model and pushes
// the outputs expected after the next rising edge. The monitor pops one
// entry per rising edge and compares tick, mismatch and err_cnt.
//
// The model keeps the tick phase as plain integers. It tracks only whether
// a nonzero injection landed on the previous edge, because the voter makes
// prescaler corruption invisible to tick timing.

module tb_tmr_tick_gen;

  localparam int W       = 8;
  localparam int ECNT_W  = 4;
  localparam int DIV_RST = 9;
  localparam int ERR_MAX = (1 << ECNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              run;
  logic              load;
  logic [W-1:0]      div;
  logic              inj_en;
  logic [1:0]        inj_sel;
  logic [W-1:0]      inj_mask;
  logic              err_clr;
  logic              tick;
  logic              mismatch;
  logic [ECNT_W-1:0] err_cnt;

  tmr_tick_gen #(.W(W), .ECNT_W(ECNT_W), .DIV_RST(DIV_RST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (load),
    .div      (div),
    .inj_en   (inj_en),
    .inj_sel  (inj_sel),
    .inj_mask (inj_mask),
    .err_clr  (err_clr),
    .tick     (tick),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              tick;
    logic              mm;
    logic [ECNT_W-1:0] err;
    int                step;
  } exp_t;

  exp_t exp_q[$];
  bit   armed;
  int   n_vec;
  int   n_miss;
  int   step_no;

  // Behavioural model state: position within the tick period, period-1,
  // error count, and whether a copy is currently corrupted.
  int m_pos;
  int m_div;
  int m_err;
  bit m_corrupt;

  task automatic apply_stimulus(input bit rn, input bit r, input bit ld,
                                input logic [W-1:0] d, input bit ie,
                                input logic [1:0] isel,
                                input logic [W-1:0] imask, input bit clr);
    exp_t e;
    @(negedge clk);
    rst_n    = rn;
    run      = r;
    load     = ld;
    div      = d;
    inj_en   = ie;
    inj_sel  = isel;
    inj_mask = imask;
    err_clr  = clr;
    e.tick = 1'b0;
    e.mm   = 1'b0;
    if (!rn) begin
      m_pos     = 0;
      m_div     = DIV_RST;
      m_err     = 0;
      m_corrupt = 1'b0;
    end else begin
      e.mm = m_corrupt;
      if (clr) m_err = 0;
      else if (m_corrupt && m_err < ERR_MAX) m_err = m_err + 1;
      if (ld) begin
        m_div = int'(d);
        m_pos = 0;
      end else if (r) begin
        // A full period is m_div+1 run cycles; tick on the last one.
        if (m_pos + 1 == m_div + 1) begin
          e.tick = 1'b1;
          m_pos  = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end
      m_corrupt = ie && (isel != 2'd3) && (imask != '0);
    end
    e.err  = ECNT_W'(m_err);
    e.step = step_no;
    step_no++;
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic cyc(input bit r, input bit ld, input int d);
    apply_stimulus(1'b1, r, ld, W'(d), 1'b0, 2'd3, '0, 1'b0);
  endtask

  task automatic check_output(input exp_t e);
    n_vec++;
    if (tick !== e.tick || mismatch !== e.mm || err_cnt !== e.err) begin
      n_miss++;
      $display("[TB] FAIL step %0d tick/mismatch/err_cnt: got %b/%b/%0d expected %b/%b/%0d",
               e.step, tick, mismatch, err_cnt, e.tick, e.mm, e.err);
    end
  endtask

  // Monitor: one output comparison per rising edge once stimulus has begun.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("[TB] FAIL queue_underflow at time %0t: got empty queue, expected an entry", $time);
        end else begin
          e = exp_q.pop_front();
          check_output(e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; load = 1'b0; div = '0;
    inj_en = 1'b0; inj_sel = 2'd3; inj_mask = '0; err_clr = 1'b0;
    armed = 1'b0; n_vec = 0; n_miss = 0; step_no = 0;
    m_pos = 0; m_div = DIV_RST; m_err = 0; m_corrupt = 1'b0;

    // Reset with every other control asserted: all of them must be ignored.
    repeat (2) apply_stimulus(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 2'd0, 8'hFF, 1'b1);

    // Free run at the reset divisor: tick every 10 cycles.
    repeat (25) cyc(1'b1, 1'b0, 0);

    // div=0: tick high on every edge after the load.
    cyc(1'b0, 1'b1, 0);
    repeat (5) cyc(1'b1, 1'b0, 0);

    // div=3, pause with the prescaler at 2, then resume.
    cyc(1'b0, 1'b1, 3);
    repeat (2) cyc(1'b1, 1'b0, 0);
    repeat (5) cyc(1'b0, 1'b0, 0);
    repeat (6) cyc(1'b1, 1'b0, 0);

    // div=9, single injection into copy 1 at prescaler 2.
    cyc(1'b0, 1'b1, 9);
    repeat (2) cyc(1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 2'd1, 8'h01, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 0);

    // Twenty separated injections saturate err_cnt at 15.
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 2'($urandom_range(0, 2)),
                     W'(1 << (k % W)), 1'b0);
      cyc(1'b1, 1'b0, 0);
    end
    // err_clr on a detection cycle wins.
    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 2'd2, 8'h10, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 2'd3, '0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 0);

    // Mid-count reset with load and injection asserted.
    repeat (4) cyc(1'b1, 1'b0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 2'd2, 8'h80, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 0);

    // Randomized traffic.
    repeat (600) begin
      logic [W-1:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      apply_stimulus($urandom_range(0, 99) != 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     rd,
                     $urandom_range(0, 3) == 0,
                     2'($urandom_range(0, 3)),
                     W'($urandom),
                     $urandom_range(0, 15) == 0);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
